gcd_initiator: RTL and testbench

- Requester side of the GCD core handshake (avail/busy/valid/req).
- Accepts operand pairs from an upstream valid/ready stream and buffers them in a small FIFO.
- Issues one pair at a time to the GCD core, collects each result with its measured latency, and presents it on a downstream valid/ready stream.
- Sits between the system bus adapter and the GCD datapath/control pair.

---
 rtl/gcd_pkg.sv | 24 ++
 rtl/gcd_opfifo.sv | 55 +++++
 rtl/gcd_initiator.sv | 142 ++++++++++++++
 tb/tb_gcd_initiator.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// ----------------------------------------------------------------------------
// gcd_pkg : shared types for the GCD initiator and core-side wrapper. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package gcd_pkg;

  localparam int GCD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2,
    ST_ACK   = 2'd3
  } gcd_state_e;

  typedef struct packed {
    logic [GCD_W-1:0] a;
    logic [GCD_W-1:0] b;
  } gcd_pair_t;

endpackage

`default_nettype wire

// File: rtl/gcd_opfifo.sv
// ----------------------------------------------------------------------------
// gcd_opfifo : synchronous operand-pair FIFO with full/empty flags. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gcd_opfifo
  import gcd_pkg::*;
#(
  parameter int DW    = $bits(gcd_pair_t),
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_one = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_one;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/gcd_initiator.sv
// ----------------------------------------------------------------------------
// gcd_initiator : queues operand pairs, drives the GCD core handshake and
// returns each result with its measured latency. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gcd_initiator
  import gcd_pkg::*;
#(
  parameter int W       = GCD_W,
  parameter int DEPTH   = 4,
  parameter int CW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_gcd,
  output logic [CW-1:0] out_cycles,
  output logic          err,
  output logic [W-1:0]  core_a,
  output logic [W-1:0]  core_b,
  output logic          core_avail,
  output logic          core_req,
  input  logic          core_busy,
  input  logic          core_valid,
  input  logic [W-1:0]  core_result
);

  localparam logic [CW-1:0] c_timeout = CW'(TIMEOUT);
  localparam logic [CW-1:0] c_one     = {{(CW-1){1'b0}}, 1'b1};

  gcd_state_e     r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_out_valid;
  logic [W-1:0]   r_out_gcd;
  logic [CW-1:0]  r_out_cycles;
  logic           r_err;
  logic [W-1:0]   r_core_a;
  logic [W-1:0]   r_core_b;
  logic           r_core_avail;
  logic           r_core_req;

  logic [2*W-1:0] w_head;
  logic           w_full;
  logic           w_empty;
  logic           w_pop;
  logic [CW-1:0]  w_cnt_next;
  logic           w_slot_free;

  gcd_opfifo #(
    .DW    (2*W),
    .DEPTH (DEPTH)
  ) u_opfifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_data  ({in_a, in_b}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign in_ready    = !w_full;
  assign w_pop       = (r_state == ST_IDLE) && !w_empty;
  assign w_cnt_next  = (&r_cnt) ? r_cnt : r_cnt + c_one;
  // A result may be captured into a slot that is being drained this cycle.
  assign w_slot_free = !r_out_valid || out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_gcd    <= '0;
      r_out_cycles <= '0;
      r_err        <= 1'b0;
      r_core_a     <= '0;
      r_core_b     <= '0;
      r_core_avail <= 1'b0;
      r_core_req   <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_core_a     <= w_head[2*W-1:W];
            r_core_b     <= w_head[W-1:0];
            r_cnt        <= '0;
            r_core_avail <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_RUN: begin
          r_cnt <= w_cnt_next;
          if (w_cnt_next == c_timeout) r_err <= 1'b1;
          // A trivial op may raise valid without ever showing busy.
          if (core_valid) begin
            r_core_avail <= 1'b0;
            if (w_slot_free) begin
              r_out_gcd    <= core_result;
              r_out_cycles <= w_cnt_next;
              r_out_valid  <= 1'b1;
              r_core_req   <= 1'b1;
              r_state      <= ST_ACK;
            end else begin
              r_state      <= ST_RUN;
            end
          end else if (core_busy) begin
            r_core_avail <= 1'b0;
            r_state      <= ST_RUN;
          end
        end
        ST_ACK: begin
          if (!core_valid) begin
            r_core_req <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_gcd    = r_out_gcd;
  assign out_cycles = r_out_cycles;
  assign err        = r_err;
  assign core_a     = r_core_a;
  assign core_b     = r_core_b;
  assign core_avail = r_core_avail;
  assign core_req   = r_core_req;

endmodule

`default_nettype wire

// File: tb/tb_gcd_initiator.sv
// ----------------------------------------------------------------------------
// tb_gcd_initiator : bench for gcd_initiator with a behavioural core and a
// queue-based scoreboard. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_gcd_initiator;

  localparam int W       = 16;
  localparam int DEPTH   = 4;
  localparam int CW      = 16;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_gcd;
  logic [CW-1:0] out_cycles;
  logic          err;
  logic [W-1:0]  core_a;
  logic [W-1:0]  core_b;
  logic          core_avail;
  logic          core_req;
  logic          core_busy = 1'b0;
  logic          core_valid = 1'b0;
  logic [W-1:0]  core_result = '0;

  always #5 clk = ~clk;

  gcd_initiator #(
    .W(W), .DEPTH(DEPTH), .CW(CW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
    .out_cycles(out_cycles), .err(err),
    .core_a(core_a), .core_b(core_b), .core_avail(core_avail),
    .core_req(core_req), .core_busy(core_busy), .core_valid(core_valid),
    .core_result(core_result)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int gcd_ref(input int a_in, input int b_in);
    int a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural GCD core: busy for core_lat cycles (frozen while stalled),
  // immediate valid when b == 0, holds the result until req is seen.
  int core_phase = 0;
  int core_cnt   = 0;
  int core_lat   = 5;
  bit core_stall = 1'b0;
  int ca, cb;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      core_phase  = 0;
      core_busy   = 1'b0;
      core_valid  = 1'b0;
      core_result = '0;
    end else begin
      case (core_phase)
        0: if (core_avail) begin
          ca = int'(core_a);
          cb = int'(core_b);
          if (cb == 0) begin
            core_valid  = 1'b1;
            core_result = W'(ca);
            core_phase  = 3;
          end else begin
            core_busy  = 1'b1;
            core_cnt   = core_lat;
            core_phase = 2;
          end
        end
        2: if (!core_stall) begin
          core_cnt--;
          if (core_cnt <= 0) begin
            core_valid  = 1'b1;
            core_result = W'(gcd_ref(ca, cb));
            core_phase  = 3;
          end
        end
        3: if (core_req) begin
          core_valid = 1'b0;
          core_busy  = 1'b0;
          core_phase = 0;
        end
        default: core_phase = 0;
      endcase
    end
  end

  bit rand_rdy = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rand_rdy) out_ready = ($urandom_range(0, 1) == 1);
  end

  // Scoreboard: operands queued on accept, result expected on issue, latency
  // measured as edges from core_avail rising to core_req rising.
  logic [2*W-1:0] op_q [$];
  int             exp_g [$];
  int             exp_c [$];
  logic [2*W-1:0] pair;
  int  edge_n  = 0;
  int  entry   = 0;
  bit  in_op   = 1'b0;
  bit  err_exp = 1'b0;
  int  n_out   = 0;
  int  last_g  = 0;
  int  last_c  = 0;
  logic p_avail = 1'b0;
  logic p_req   = 1'b0;

  initial forever begin
    @(negedge clk);
    #1;
    edge_n++;
    if (!rst) begin
      op_q.delete();
      exp_g.delete();
      exp_c.delete();
      in_op   = 1'b0;
      err_exp = 1'b0;
      p_avail = 1'b0;
      p_req   = 1'b0;
    end else begin
      if (core_avail && !p_avail) begin
        if (op_q.size() == 0) check("spurious_issue", 1, 0);
        else begin
          pair = op_q.pop_front();
          check("core_a", core_a, pair[2*W-1:W]);
          check("core_b", core_b, pair[W-1:0]);
          exp_g.push_back(gcd_ref(int'(pair[2*W-1:W]), int'(pair[W-1:0])));
        end
        entry = edge_n;
        in_op = 1'b1;
      end
      if (in_op && (edge_n - entry) >= TIMEOUT) err_exp = 1'b1;
      if (core_req && !p_req) begin
        exp_c.push_back(edge_n - entry);
        in_op = 1'b0;
      end
      check("in_ready", in_ready, (op_q.size() < DEPTH) ? 1 : 0);
      check("err", err, err_exp);
      check("out_valid", out_valid, (exp_c.size() != 0) ? 1 : 0);
      if (out_valid && exp_c.size() != 0 && exp_g.size() != 0) begin
        check("out_gcd", out_gcd, exp_g[0]);
        check("out_cycles", out_cycles, exp_c[0]);
        if (out_ready) begin
          void'(exp_g.pop_front());
          void'(exp_c.pop_front());
          last_g = int'(out_gcd);
          last_c = int'(out_cycles);
          n_out++;
        end
      end
      if (in_valid && in_ready) op_q.push_back({in_a, in_b});
      p_avail = core_avail;
      p_req   = core_req;
    end
  end

  int n_push = 0;

  task automatic push(input int a, input int b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = W'(a);
    in_b = W'(b);
    #2;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 300) check("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_push++;
  endtask

  task automatic wait_out(input int target);
    int n;
    n = 0;
    while (n_out < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n_out < target) check("wait_out_timeout", n_out, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_gcd"}, out_gcd, 0);
    check({tag, "_out_cycles"}, out_cycles, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_core_a"}, core_a, 0);
    check({tag, "_core_b"}, core_b, 0);
    check({tag, "_core_avail"}, core_avail, 0);
    check({tag, "_core_req"}, core_req, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    int a, b, g, n, k;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;

    // Single op, 5-cycle compute: busy edge + 5 countdown edges.
    core_lat = 5;
    push(48, 18);
    wait_out(1);
    check("single_gcd", last_g, 6);
    check("single_cycles", last_c, 6);
    repeat (3) @(negedge clk);
    #2;
    check("single_req_dropped", core_req, 0);

    // b = 0: valid comes straight from ISSUE.
    push(7, 0);
    wait_out(2);
    check("b0_gcd", last_g, 7);
    check("b0_cycles", last_c, 1);
    repeat (3) @(negedge clk);
    #2;
    check("b0_single_pulse", out_valid, 0);

    // Back-pressure: second op must wait in RUN without acknowledging.
    out_ready = 1'b0;
    push(48, 18);
    push(35, 14);
    repeat (25) @(negedge clk);
    #2;
    check("bp_held_valid", out_valid, 1);
    check("bp_held_gcd", out_gcd, 6);
    check("bp_core_req_low", core_req, 0);
    check("bp_core_holds", core_valid, 1);
    @(negedge clk);
    out_ready = 1'b1;
    wait_out(4);
    check("bp_second_gcd", last_g, 7);

    // FIFO full with the core stalled.
    repeat (4) @(negedge clk);
    core_stall = 1'b1;
    push(84, 36);
    push(100, 75);
    push(81, 27);
    push(17, 5);
    push(60, 48);
    check("fifo_full_ready", in_ready, 0);
    repeat (5) @(negedge clk);
    core_stall = 1'b0;
    wait_out(n_push);

    // Randomized traffic.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      core_lat = $urandom_range(1, 6);
      g = $urandom_range(1, 50);
      a = g * $urandom_range(0, 300);
      b = ($urandom_range(0, 7) == 0) ? 0 : g * $urandom_range(0, 300);
      push(a, b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    wait_out(n_push);

    // Timeout: err rises on the cycle the counter reaches TIMEOUT.
    repeat (4) @(negedge clk);
    core_stall = 1'b1;
    core_lat = 3;
    push(100, 75);
    n = 0;
    while (!in_op && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    n = 0;
    while (edge_n < entry + TIMEOUT - 1 && n < 500) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("err_before_timeout", err, 0);
    @(negedge clk);
    #2;
    check("err_at_timeout", err, 1);
    check("timeout_avail_dropped", core_avail, 0);
    core_stall = 1'b0;
    wait_out(n_push);
    check("timeout_gcd", last_g, 25);
    repeat (3) @(negedge clk);
    #2;
    check("err_sticky", err, 1);

    // Reset mid-operation with two pairs queued.
    core_stall = 1'b1;
    push(30, 12);
    push(9, 6);
    push(8, 4);
    repeat (3) @(negedge clk);
    #2;
    check("midop_busy", core_busy, 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    core_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    k = n_out;
    push(12, 8);
    wait_out(k + 1);
    check("after_reset_gcd", last_g, 4);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
